// File: rtl/pixel_row_packer_pkg.sv
// Sensor geometry and output bus defaults shared by the pixel row packer and its bench.
package PixelSensorConfig;

    localparam int unsigned PIXEL_ARRAY_WIDTH_DFLT  = 24;
    localparam int unsigned PIXEL_ARRAY_HEIGHT_DFLT = 12;
    localparam int unsigned PIXEL_BITS_DFLT         = 8;
    localparam int unsigned OUTPUT_BUS_WIDTH_DFLT   = 8;
    localparam int unsigned WORD_BITS               = PIXEL_BITS_DFLT * OUTPUT_BUS_WIDTH_DFLT;
    localparam int unsigned FRAME_COUNT_BITS        = 16;

    typedef logic [WORD_BITS-1:0] word_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_word_fifo.sv
// Two-entry word FIFO; head and valid come straight from registers.
module pixel_word_fifo
    import PixelSensorConfig::*;
#(
    parameter int unsigned DATA_W = WORD_BITS + 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              valid,
    output logic              full
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              do_push;
    logic              do_pop;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop & (count_q != 2'd0);
    assign do_push = push & ((count_q != 2'd2) | do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign valid = (count_q != 2'd0);
    assign full  = (count_q == 2'd2);

endmodule

// File: rtl/pixel_row_packer.sv
// Packs raster-order pixels into multi-pixel words with row/frame markers and SOF realignment.
module pixel_row_packer
    import PixelSensorConfig::*;
#(
    parameter int unsigned PIXEL_ARRAY_WIDTH  = PIXEL_ARRAY_WIDTH_DFLT,
    parameter int unsigned PIXEL_ARRAY_HEIGHT = PIXEL_ARRAY_HEIGHT_DFLT,
    parameter int unsigned PIXEL_BITS         = PIXEL_BITS_DFLT,
    parameter int unsigned OUTPUT_BUS_WIDTH   = OUTPUT_BUS_WIDTH_DFLT
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [PIXEL_BITS-1:0]                in_pixel,
    input  logic                                 in_sof,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [PIXEL_BITS*OUTPUT_BUS_WIDTH-1:0] out_data,
    output logic                                 out_row_last,
    output logic                                 out_frame_last,
    output logic                                 sof_error,
    output logic [FRAME_COUNT_BITS-1:0]          frame_count
);

    localparam int unsigned WORD_W  = PIXEL_BITS * OUTPUT_BUS_WIDTH;
    localparam int unsigned ENTRY_W = WORD_W + 2;
    localparam int unsigned COL_W   = cnt_width(PIXEL_ARRAY_WIDTH);
    localparam int unsigned ROW_W   = cnt_width(PIXEL_ARRAY_HEIGHT);
    localparam int unsigned LANE_W  = cnt_width(OUTPUT_BUS_WIDTH);

    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(PIXEL_ARRAY_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(OUTPUT_BUS_WIDTH - 1);

    logic [COL_W-1:0]   col_q, col_d, eff_col;
    logic [ROW_W-1:0]   row_q, row_d, eff_row;
    logic [LANE_W-1:0]  lane_q, lane_d, eff_lane;
    logic [WORD_W-1:0]  partial_q, word_c;
    logic               ready_en_q;
    logic               fifo_full;
    logic               accept;
    logic               realign;
    logic               push;
    logic               pop;
    logic               row_last_c;
    logic               frame_last_c;
    logic [ENTRY_W-1:0] head;

    // ready_en_q holds in_ready low through reset and for the release cycle.
    assign in_ready = ready_en_q & ~fifo_full;
    assign accept   = in_valid & in_ready;
    assign realign  = accept & in_sof & ((col_q != '0) | (row_q != '0));
    assign pop      = out_valid & out_ready;

    // A misplaced SOF restarts the frame: its pixel becomes (0,0) in an empty word.
    always_comb begin
        eff_col  = realign ? '0 : col_q;
        eff_row  = realign ? '0 : row_q;
        eff_lane = realign ? '0 : lane_q;
        word_c   = realign ? '0 : partial_q;
        word_c[eff_lane*PIXEL_BITS +: PIXEL_BITS] = in_pixel;

        row_last_c   = (eff_col == COL_MAX);
        frame_last_c = row_last_c & (eff_row == ROW_MAX);
        push         = accept & (eff_lane == LANE_MAX);

        col_d  = row_last_c ? '0 : eff_col + COL_W'(1);
        row_d  = eff_row;
        if (row_last_c) begin
            row_d = (eff_row == ROW_MAX) ? '0 : eff_row + ROW_W'(1);
        end
        lane_d = (eff_lane == LANE_MAX) ? '0 : eff_lane + LANE_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en_q  <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            lane_q      <= '0;
            partial_q   <= '0;
            sof_error   <= 1'b0;
            frame_count <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (accept) begin
                col_q     <= col_d;
                row_q     <= row_d;
                lane_q    <= lane_d;
                partial_q <= push ? '0 : word_c;
            end
            if (realign) begin
                sof_error <= 1'b1;
            end
            if (pop && head[ENTRY_W-1]) begin
                frame_count <= frame_count + FRAME_COUNT_BITS'(1);
            end
        end
    end

    pixel_word_fifo #(
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({frame_last_c, row_last_c, word_c}),
        .pop       (pop),
        .head      (head),
        .valid     (out_valid),
        .full      (fifo_full)
    );

    assign out_frame_last = head[ENTRY_W-1];
    assign out_row_last   = head[ENTRY_W-2];
    assign out_data       = head[WORD_W-1:0];

endmodule

// File: tb/tb_pixel_row_packer.sv
// Directed bench for pixel_row_packer at default 24x12 geometry, 8 x 8-bit pixels per word.
module tb_pixel_row_packer;
    import PixelSensorConfig::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pixel;
    logic        in_sof;
    logic        out_valid;
    logic        out_ready;
    word_t       out_data;
    logic        out_row_last;
    logic        out_frame_last;
    logic        sof_error;
    logic [15:0] frame_count;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] data;
        logic        rl;
        logic        fl;
        int          cyc;
    } word_rec_t;

    word_rec_t mon_q[$];

    pixel_row_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pixel       (in_pixel),
        .in_sof         (in_sof),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_row_last   (out_row_last),
        .out_frame_last (out_frame_last),
        .sof_error      (sof_error),
        .frame_count    (frame_count)
    );

    always #5 clk = ~clk;

    // Log every popped word with the index of the cycle it was presented in.
    always @(posedge clk) begin
        if (reset_n && out_valid && out_ready)
            mon_q.push_back('{out_data, out_row_last, out_frame_last, cyc});
        cyc <= cyc + 1;
    end

    task automatic send(input logic [7:0] p, input logic s);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_pixel = p;
        in_sof   = s;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; fails++;
            $display("FAIL send_timeout: in_ready got 0 required 1");
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        reset_n   = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0; out_ready = 1'b1;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        idle(1);
        checks++; if (out_valid !== 1'b0)      begin fails++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== 64'h0)      begin fails++; $display("FAIL rst_out_data: got %h required 0", out_data); end
        checks++; if (out_row_last !== 1'b0)   begin fails++; $display("FAIL rst_row_last: got %b required 0", out_row_last); end
        checks++; if (out_frame_last !== 1'b0) begin fails++; $display("FAIL rst_frame_last: got %b required 0", out_frame_last); end
        checks++; if (sof_error !== 1'b0)      begin fails++; $display("FAIL rst_sof_error: got %b required 0", sof_error); end
        checks++; if (frame_count !== 16'h0)   begin fails++; $display("FAIL rst_frame_count: got %h required 0", frame_count); end
        checks++; if (in_ready !== 1'b0)       begin fails++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0)       begin fails++; $display("FAIL release_in_ready_early: got %b required 0", in_ready); end
        idle(1);
        checks++; if (in_ready !== 1'b1)       begin fails++; $display("FAIL release_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_row();
        int t0;
        mon_q.delete();
        out_ready = 1'b1;
        send(8'd0, 1'b1);
        t0 = cyc;
        for (int c = 1; c < 24; c++) send(8'(c), 1'b0);
        idle(3);
        checks++; if (mon_q.size() !== 3) begin fails++; $display("FAIL row_word_count: got %0d required 3", mon_q.size()); end
        if (mon_q.size() == 3) begin
            checks++; if (mon_q[0].data !== 64'h0706050403020100) begin fails++; $display("FAIL row_word0: got %h required 0706050403020100", mon_q[0].data); end
            checks++; if (mon_q[1].data !== 64'h0f0e0d0c0b0a0908) begin fails++; $display("FAIL row_word1: got %h required 0f0e0d0c0b0a0908", mon_q[1].data); end
            checks++; if (mon_q[2].data !== 64'h1716151413121110) begin fails++; $display("FAIL row_word2: got %h required 1716151413121110", mon_q[2].data); end
            checks++; if ({mon_q[0].rl, mon_q[1].rl, mon_q[2].rl} !== 3'b001) begin fails++; $display("FAIL row_last_pattern: got %b required 001", {mon_q[0].rl, mon_q[1].rl, mon_q[2].rl}); end
            checks++; if ({mon_q[0].fl, mon_q[1].fl, mon_q[2].fl} !== 3'b000) begin fails++; $display("FAIL row_frame_last: got %b required 000", {mon_q[0].fl, mon_q[1].fl, mon_q[2].fl}); end
            checks++; if (mon_q[0].cyc !== t0 + 7)  begin fails++; $display("FAIL row_word0_cycle: got %0d required %0d", mon_q[0].cyc, t0 + 7); end
            checks++; if (mon_q[1].cyc !== t0 + 15) begin fails++; $display("FAIL row_word1_cycle: got %0d required %0d", mon_q[1].cyc, t0 + 15); end
            checks++; if (mon_q[2].cyc !== t0 + 23) begin fails++; $display("FAIL row_word2_cycle: got %0d required %0d", mon_q[2].cyc, t0 + 23); end
        end
        checks++; if (frame_count !== 16'h0) begin fails++; $display("FAIL row_frame_count: got %h required 0", frame_count); end
    endtask

    task automatic test_frame();
        logic [63:0] exp;
        int          bad_data, bad_rl, bad_fl;
        mon_q.delete();
        bad_data = 0; bad_rl = 0; bad_fl = 0;
        checks++; if (frame_count !== 16'h0) begin fails++; $display("FAIL frame_count_before: got %h required 0", frame_count); end
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 24; c++)
                send(8'(r * 24 + c), (r == 0) && (c == 0));
        idle(3);
        checks++; if (mon_q.size() !== 36) begin fails++; $display("FAIL frame_word_count: got %0d required 36", mon_q.size()); end
        for (int i = 0; i < mon_q.size() && i < 36; i++) begin
            for (int k = 0; k < 8; k++) exp[k*8 +: 8] = 8'(8 * i + k);
            if (mon_q[i].data !== exp)          bad_data++;
            if (mon_q[i].rl !== (i % 3 == 2))   bad_rl++;
            if (mon_q[i].fl !== (i == 35))      bad_fl++;
        end
        checks++; if (bad_data !== 0) begin fails++; $display("FAIL frame_data: got %0d bad words required 0", bad_data); end
        checks++; if (bad_rl !== 0)   begin fails++; $display("FAIL frame_row_last: got %0d bad words required 0", bad_rl); end
        checks++; if (bad_fl !== 0)   begin fails++; $display("FAIL frame_frame_last: got %0d bad words required 0", bad_fl); end
        checks++; if (frame_count !== 16'h1) begin fails++; $display("FAIL frame_count_after: got %h required 1", frame_count); end
    endtask

    task automatic test_backpressure();
        int n;
        mon_q.delete();
        out_ready = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        while (in_ready && n < 40) begin
            in_pixel = 8'(n);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        checks++; if (n !== 16)          begin fails++; $display("FAIL bp_accepted: got %0d required 16", n); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 64'h0706050403020100 || out_row_last !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold_%0d: got valid=%b data=%h rl=%b required valid=1 data=0706050403020100 rl=0", i, out_valid, out_data, out_row_last);
            end
            idle(1);
        end
        out_ready = 1'b1;
        for (int c = 16; c < 24; c++) send(8'(c), 1'b0);
        idle(3);
        checks++; if (mon_q.size() !== 3) begin fails++; $display("FAIL bp_word_count: got %0d required 3", mon_q.size()); end
        if (mon_q.size() == 3) begin
            checks++; if (mon_q[0].data !== 64'h0706050403020100) begin fails++; $display("FAIL bp_word0: got %h required 0706050403020100", mon_q[0].data); end
            checks++; if (mon_q[1].data !== 64'h0f0e0d0c0b0a0908) begin fails++; $display("FAIL bp_word1: got %h required 0f0e0d0c0b0a0908", mon_q[1].data); end
            checks++; if (mon_q[2].data !== 64'h1716151413121110 || mon_q[2].rl !== 1'b1) begin fails++; $display("FAIL bp_word2: got %h rl=%b required 1716151413121110 rl=1", mon_q[2].data, mon_q[2].rl); end
        end
    endtask

    task automatic test_sof_realign();
        mon_q.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) send(8'(8'hA0 + c), c == 0);
        checks++; if (sof_error !== 1'b0) begin fails++; $display("FAIL sof_error_before: got %b required 0", sof_error); end
        send(8'h55, 1'b1);
        checks++; if (sof_error !== 1'b1) begin fails++; $display("FAIL sof_error_set: got %b required 1", sof_error); end
        for (int i = 1; i < 8; i++) send(8'(8'h55 + i), 1'b0);
        for (int i = 0; i < 16; i++) send(8'(8'h60 + i), 1'b0);
        idle(3);
        checks++; if (mon_q.size() !== 3) begin fails++; $display("FAIL sof_word_count: got %0d required 3", mon_q.size()); end
        if (mon_q.size() == 3) begin
            checks++; if (mon_q[0].data !== 64'h5c5b5a5958575655) begin fails++; $display("FAIL sof_word0: got %h required 5c5b5a5958575655", mon_q[0].data); end
            checks++; if (mon_q[2].data !== 64'h6f6e6d6c6b6a6968) begin fails++; $display("FAIL sof_word2: got %h required 6f6e6d6c6b6a6968", mon_q[2].data); end
            checks++; if ({mon_q[0].rl, mon_q[1].rl, mon_q[2].rl} !== 3'b001) begin fails++; $display("FAIL sof_row_last: got %b required 001", {mon_q[0].rl, mon_q[1].rl, mon_q[2].rl}); end
        end
        checks++; if (sof_error !== 1'b1 || frame_count !== 16'h1) begin fails++; $display("FAIL sof_sticky: got err=%b fc=%h required err=1 fc=1", sof_error, frame_count); end
    endtask

    task automatic test_reset_mid_row();
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) send(8'(8'hC0 + i), 1'b0);
        idle(1);
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid: got %b required 1", out_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0)      begin fails++; $display("FAIL mid_out_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== 64'h0)      begin fails++; $display("FAIL mid_out_data: got %h required 0", out_data); end
        checks++; if (out_row_last !== 1'b0 || out_frame_last !== 1'b0) begin fails++; $display("FAIL mid_flags: got rl=%b fl=%b required 0 0", out_row_last, out_frame_last); end
        checks++; if (sof_error !== 1'b0)      begin fails++; $display("FAIL mid_sof_error: got %b required 0", sof_error); end
        checks++; if (frame_count !== 16'h0)   begin fails++; $display("FAIL mid_frame_count: got %h required 0", frame_count); end
        checks++; if (in_ready !== 1'b0)       begin fails++; $display("FAIL mid_in_ready: got %b required 0", in_ready); end
        idle(1);
        reset_n = 1'b1;
        idle(1);
        out_ready = 1'b1;
        mon_q.delete();
        for (int i = 0; i < 24; i++) send(8'(8'h30 + i), 1'b0);
        idle(3);
        checks++; if (mon_q.size() !== 3) begin fails++; $display("FAIL mid_word_count: got %0d required 3", mon_q.size()); end
        if (mon_q.size() == 3) begin
            checks++; if (mon_q[0].data !== 64'h3736353433323130) begin fails++; $display("FAIL mid_word0: got %h required 3736353433323130", mon_q[0].data); end
            checks++; if ({mon_q[0].rl, mon_q[1].rl, mon_q[2].rl} !== 3'b001) begin fails++; $display("FAIL mid_row_last: got %b required 001", {mon_q[0].rl, mon_q[1].rl, mon_q[2].rl}); end
        end
    endtask

    initial begin
        test_reset();
        test_row();
        do_reset();
        test_backpressure();
        do_reset();
        test_frame();
        test_sof_realign();
        test_reset_mid_row();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
